// File: rtl/mem_arbiter.sv
// Two-master quantum round-robin arbiter in front of the mem_xbar data port.
// Tracks in-flight reads so returning data is steered to the issuing master.
module mem_arbiter #(
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned QUANTUM      = 4
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        i_m0_req,
    input  logic [29:0] i_m0_addr,
    input  logic [31:0] i_m0_data,
    input  logic [3:0]  i_m0_mask,
    input  logic        i_m0_wren,
    output logic        o_m0_gnt,
    output logic        o_m0_rvalid,
    output logic [31:0] o_m0_rdata,

    input  logic        i_m1_req,
    input  logic [29:0] i_m1_addr,
    input  logic [31:0] i_m1_data,
    input  logic [3:0]  i_m1_mask,
    input  logic        i_m1_wren,
    output logic        o_m1_gnt,
    output logic        o_m1_rvalid,
    output logic [31:0] o_m1_rdata,

    output logic [29:0] o_mem_addr,
    output logic [31:0] o_mem_data,
    output logic [3:0]  o_mem_mask,
    output logic        o_mem_wren,
    input  logic [31:0] i_mem_data
);

    localparam logic [3:0]  QuantumC = 4'(QUANTUM);
    localparam int unsigned LastIdx  = READ_LATENCY - 1;

    logic                    owner_q, owner_d;
    logic [3:0]              run_cnt_q, run_cnt_d;
    logic [READ_LATENCY-1:0] pipe_vld_q, pipe_vld_d;
    logic [READ_LATENCY-1:0] pipe_id_q, pipe_id_d;

    logic gnt0, gnt1, accept, win_id, out_vld;

    // Grant selection; the owner keeps priority until its quantum is spent.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (rst_n) begin
            if (i_m0_req && i_m1_req) begin
                if (run_cnt_q < QuantumC) begin
                    gnt0 = ~owner_q;
                    gnt1 = owner_q;
                end else begin
                    gnt0 = owner_q;
                    gnt1 = ~owner_q;
                end
            end else begin
                gnt0 = i_m0_req;
                gnt1 = i_m1_req;
            end
        end
    end

    assign accept   = gnt0 | gnt1;
    assign win_id   = gnt1;
    assign o_m0_gnt = gnt0;
    assign o_m1_gnt = gnt1;

    always_comb begin
        o_mem_addr = '0;
        o_mem_data = '0;
        o_mem_mask = '0;
        o_mem_wren = 1'b0;
        if (gnt1) begin
            o_mem_addr = i_m1_addr;
            o_mem_data = i_m1_data;
            o_mem_mask = i_m1_mask;
            o_mem_wren = i_m1_wren;
        end else if (gnt0) begin
            o_mem_addr = i_m0_addr;
            o_mem_data = i_m0_data;
            o_mem_mask = i_m0_mask;
            o_mem_wren = i_m0_wren;
        end
    end

    always_comb begin
        owner_d   = owner_q;
        run_cnt_d = run_cnt_q;
        if (accept) begin
            if (win_id == owner_q) begin
                if (run_cnt_q < QuantumC) begin
                    run_cnt_d = run_cnt_q + 4'd1;
                end
            end else begin
                owner_d   = win_id;
                run_cnt_d = 4'd1;
            end
        end
    end

    // Read-tracking shift register: entry 0 is the newest accepted transfer.
    always_comb begin
        pipe_vld_d    = '0;
        pipe_id_d     = '0;
        pipe_vld_d[0] = accept & ~o_mem_wren;
        pipe_id_d[0]  = win_id;
        for (int i = 1; i < int'(READ_LATENCY); i++) begin
            pipe_vld_d[i] = pipe_vld_q[i-1];
            pipe_id_d[i]  = pipe_id_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            owner_q    <= 1'b0;
            run_cnt_q  <= 4'd0;
            pipe_vld_q <= '0;
            pipe_id_q  <= '0;
        end else begin
            owner_q    <= owner_d;
            run_cnt_q  <= run_cnt_d;
            pipe_vld_q <= pipe_vld_d;
            pipe_id_q  <= pipe_id_d;
        end
    end

    assign out_vld     = rst_n & pipe_vld_q[LastIdx];
    assign o_m0_rvalid = out_vld & ~pipe_id_q[LastIdx];
    assign o_m1_rvalid = out_vld & pipe_id_q[LastIdx];
    assign o_m0_rdata  = o_m0_rvalid ? i_mem_data : '0;
    assign o_m1_rdata  = o_m1_rvalid ? i_mem_data : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: instance A (latency 1, quantum 4) with a
// writable memory model, instance B (latency 3, quantum 1) with address-derived read data.
module tb_mem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic preload;
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Instance A
    logic        a_rst_n;
    logic        a_m0_req, a_m0_wren, a_m0_gnt, a_m0_rvalid;
    logic [29:0] a_m0_addr;
    logic [31:0] a_m0_data, a_m0_rdata;
    logic [3:0]  a_m0_mask;
    logic        a_m1_req, a_m1_wren, a_m1_gnt, a_m1_rvalid;
    logic [29:0] a_m1_addr;
    logic [31:0] a_m1_data, a_m1_rdata;
    logic [3:0]  a_m1_mask;
    logic [29:0] a_mem_addr;
    logic [31:0] a_mem_data, a_mem_rdata;
    logic [3:0]  a_mem_mask;
    logic        a_mem_wren;

    mem_arbiter #(.READ_LATENCY(1), .QUANTUM(4)) u_dut_a (
        .clk         (clk),
        .rst_n       (a_rst_n),
        .i_m0_req    (a_m0_req),
        .i_m0_addr   (a_m0_addr),
        .i_m0_data   (a_m0_data),
        .i_m0_mask   (a_m0_mask),
        .i_m0_wren   (a_m0_wren),
        .o_m0_gnt    (a_m0_gnt),
        .o_m0_rvalid (a_m0_rvalid),
        .o_m0_rdata  (a_m0_rdata),
        .i_m1_req    (a_m1_req),
        .i_m1_addr   (a_m1_addr),
        .i_m1_data   (a_m1_data),
        .i_m1_mask   (a_m1_mask),
        .i_m1_wren   (a_m1_wren),
        .o_m1_gnt    (a_m1_gnt),
        .o_m1_rvalid (a_m1_rvalid),
        .o_m1_rdata  (a_m1_rdata),
        .o_mem_addr  (a_mem_addr),
        .o_mem_data  (a_mem_data),
        .o_mem_mask  (a_mem_mask),
        .o_mem_wren  (a_mem_wren),
        .i_mem_data  (a_mem_rdata)
    );

    logic [31:0] mem_a [64];
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 64; i++) mem_a[i] <= 32'h1000_0000 + i;
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (a_mem_wren && a_mem_mask[b])
                    mem_a[a_mem_addr[5:0]][8*b +: 8] <= a_mem_data[8*b +: 8];
            end
            a_mem_rdata <= mem_a[a_mem_addr[5:0]];
        end
    end

    // Instance B
    logic        b_rst_n;
    logic        b_m0_req, b_m0_wren, b_m0_gnt, b_m0_rvalid;
    logic [29:0] b_m0_addr;
    logic [31:0] b_m0_data, b_m0_rdata;
    logic [3:0]  b_m0_mask;
    logic        b_m1_req, b_m1_wren, b_m1_gnt, b_m1_rvalid;
    logic [29:0] b_m1_addr;
    logic [31:0] b_m1_data, b_m1_rdata;
    logic [3:0]  b_m1_mask;
    logic [29:0] b_mem_addr;
    logic [31:0] b_mem_data;
    logic [3:0]  b_mem_mask;
    logic        b_mem_wren;
    logic [31:0] rd_b [3];

    mem_arbiter #(.READ_LATENCY(3), .QUANTUM(1)) u_dut_b (
        .clk         (clk),
        .rst_n       (b_rst_n),
        .i_m0_req    (b_m0_req),
        .i_m0_addr   (b_m0_addr),
        .i_m0_data   (b_m0_data),
        .i_m0_mask   (b_m0_mask),
        .i_m0_wren   (b_m0_wren),
        .o_m0_gnt    (b_m0_gnt),
        .o_m0_rvalid (b_m0_rvalid),
        .o_m0_rdata  (b_m0_rdata),
        .i_m1_req    (b_m1_req),
        .i_m1_addr   (b_m1_addr),
        .i_m1_data   (b_m1_data),
        .i_m1_mask   (b_m1_mask),
        .i_m1_wren   (b_m1_wren),
        .o_m1_gnt    (b_m1_gnt),
        .o_m1_rvalid (b_m1_rvalid),
        .o_m1_rdata  (b_m1_rdata),
        .o_mem_addr  (b_mem_addr),
        .o_mem_data  (b_mem_data),
        .o_mem_mask  (b_mem_mask),
        .o_mem_wren  (b_mem_wren),
        .i_mem_data  (rd_b[2])
    );

    // Read-only memory for B: word at address A holds 0x4000_0000 | A.
    always @(posedge clk) begin
        rd_b[0] <= 32'h4000_0000 | {2'b00, b_mem_addr};
        rd_b[1] <= rd_b[0];
        rd_b[2] <= rd_b[1];
    end

    task automatic cyc_start();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic e1, p1;
        logic [31:0] exp_rd;

        preload   = 1'b1;
        a_rst_n   = 1'b0;
        a_m0_req  = 1'b1; a_m0_addr = 30'h10; a_m0_data = '0; a_m0_mask = 4'hF; a_m0_wren = 1'b0;
        a_m1_req  = 1'b1; a_m1_addr = 30'h20; a_m1_data = '0; a_m1_mask = 4'hF; a_m1_wren = 1'b0;
        b_rst_n   = 1'b0;
        b_m0_req  = 1'b0; b_m0_addr = 30'h10; b_m0_data = '0; b_m0_mask = 4'h0; b_m0_wren = 1'b0;
        b_m1_req  = 1'b0; b_m1_addr = 30'h20; b_m1_data = '0; b_m1_mask = 4'h0; b_m1_wren = 1'b0;

        // Reset held for two cycles with both masters requesting
        for (int r = 0; r < 2; r++) begin
            cyc_start();
            preload = 1'b0;
            #1;
            check($sformatf("rst%0d gnt0", r), 32'(a_m0_gnt), 32'd0);
            check($sformatf("rst%0d gnt1", r), 32'(a_m1_gnt), 32'd0);
            check($sformatf("rst%0d rvalid", r), 32'({a_m0_rvalid, a_m1_rvalid}), 32'd0);
            check($sformatf("rst%0d mem_addr", r), 32'(a_mem_addr), 32'd0);
            check($sformatf("rst%0d mem_wren", r), 32'(a_mem_wren), 32'd0);
        end

        // Continuous contention: m0 x4, m1 x4, m0 x4, data returns one cycle later
        for (int k = 0; k < 13; k++) begin
            cyc_start();
            a_rst_n  = 1'b1;
            a_m0_req = (k < 12);
            a_m1_req = (k < 12);
            #1;
            e1 = ((k / 4) % 2) == 1;
            if (k < 12) begin
                check($sformatf("cont%0d gnt0", k), 32'(a_m0_gnt), 32'(!e1));
                check($sformatf("cont%0d gnt1", k), 32'(a_m1_gnt), 32'(e1));
                check($sformatf("cont%0d addr", k), 32'(a_mem_addr), e1 ? 32'h20 : 32'h10);
            end else begin
                check("cont idle gnt", 32'({a_m0_gnt, a_m1_gnt}), 32'd0);
                check("cont idle addr", 32'(a_mem_addr), 32'd0);
            end
            if (k > 0) begin
                p1 = (((k - 1) / 4) % 2) == 1;
                exp_rd = p1 ? 32'h1000_0020 : 32'h1000_0010;
                check($sformatf("cont%0d rv0", k), 32'(a_m0_rvalid), 32'(!p1));
                check($sformatf("cont%0d rv1", k), 32'(a_m1_rvalid), 32'(p1));
                check($sformatf("cont%0d rd0", k), a_m0_rdata, p1 ? 32'd0 : exp_rd);
                check($sformatf("cont%0d rd1", k), a_m1_rdata, p1 ? exp_rd : 32'd0);
            end
        end
        cyc_start();
        #1;
        check("cont tail rvalid", 32'({a_m0_rvalid, a_m1_rvalid}), 32'd0);

        // Solo m1 writes, one grant per cycle
        for (int i = 0; i < 10; i++) begin
            cyc_start();
            a_m1_req = 1'b1; a_m1_wren = 1'b1; a_m1_addr = 30'(i);
            a_m1_data = 32'hA5A5_0000 + i; a_m1_mask = 4'hF;
            #1;
            check($sformatf("solo_wr%0d gnt1", i), 32'(a_m1_gnt), 32'd1);
            check($sformatf("solo_wr%0d gnt0", i), 32'(a_m0_gnt), 32'd0);
            check($sformatf("solo_wr%0d wren", i), 32'(a_mem_wren), 32'd1);
            check($sformatf("solo_wr%0d data", i), a_mem_data, 32'hA5A5_0000 + i);
            check($sformatf("solo_wr%0d rv", i), 32'({a_m0_rvalid, a_m1_rvalid}), 32'd0);
        end
        // Read back
        for (int i = 0; i < 11; i++) begin
            cyc_start();
            a_m1_req = (i < 10); a_m1_wren = 1'b0; a_m1_addr = 30'(i); a_m1_data = '0;
            #1;
            if (i < 10) check($sformatf("solo_rd%0d gnt1", i), 32'(a_m1_gnt), 32'd1);
            if (i > 0) begin
                check($sformatf("solo_rd%0d rv1", i), 32'(a_m1_rvalid), 32'd1);
                check($sformatf("solo_rd%0d rd1", i), a_m1_rdata, 32'hA5A5_0000 + i - 1);
                check($sformatf("solo_rd%0d rv0", i), 32'(a_m0_rvalid), 32'd0);
            end
        end

        // m0 writes addr 5, m1 reads it the next cycle
        cyc_start();
        a_m1_req = 1'b0;
        a_m0_req = 1'b1; a_m0_wren = 1'b1; a_m0_addr = 30'd5; a_m0_data = 32'hDEAD_BEEF;
        #1;
        check("intl wr gnt0", 32'(a_m0_gnt), 32'd1);
        cyc_start();
        a_m0_req = 1'b0; a_m0_wren = 1'b0; a_m0_data = '0;
        a_m1_req = 1'b1; a_m1_wren = 1'b0; a_m1_addr = 30'd5;
        #1;
        check("intl rd gnt1", 32'(a_m1_gnt), 32'd1);
        check("intl rd rv0", 32'(a_m0_rvalid), 32'd0);
        cyc_start();
        a_m1_req = 1'b0;
        #1;
        check("intl rv1", 32'(a_m1_rvalid), 32'd1);
        check("intl rd1", a_m1_rdata, 32'hDEAD_BEEF);
        check("intl rv0", 32'(a_m0_rvalid), 32'd0);
        check("intl rd0", a_m0_rdata, 32'd0);

        // B: reset the cycle after a read is accepted; the response must vanish
        cyc_start();
        b_rst_n = 1'b1; b_m0_req = 1'b1; b_m0_addr = 30'd3;
        #1;
        check("midrst gnt0", 32'(b_m0_gnt), 32'd1);
        check("midrst addr", 32'(b_mem_addr), 32'd3);
        cyc_start();
        b_rst_n = 1'b0; b_m0_req = 1'b0;
        #1;
        check("midrst low rv", 32'({b_m0_rvalid, b_m1_rvalid}), 32'd0);
        for (int j = 0; j < 4; j++) begin
            cyc_start();
            b_rst_n = 1'b1;
            #1;
            check($sformatf("midrst post%0d rv", j), 32'({b_m0_rvalid, b_m1_rvalid}), 32'd0);
        end

        // B: quantum 1 alternation, latency 3 returns
        b_m0_addr = 30'h10;
        b_m1_addr = 30'h20;
        for (int k = 0; k < 14; k++) begin
            cyc_start();
            b_m0_req = (k < 10);
            b_m1_req = (k < 10);
            #1;
            if (k < 10) begin
                check($sformatf("sweep%0d gnt0", k), 32'(b_m0_gnt), 32'((k % 2) == 0));
                check($sformatf("sweep%0d gnt1", k), 32'(b_m1_gnt), 32'((k % 2) == 1));
                check($sformatf("sweep%0d wren", k), 32'(b_mem_wren), 32'd0);
            end
            if (k >= 3 && k <= 12) begin
                p1 = ((k - 3) % 2) == 1;
                exp_rd = p1 ? 32'h4000_0020 : 32'h4000_0010;
                check($sformatf("sweep%0d rv0", k), 32'(b_m0_rvalid), 32'(!p1));
                check($sformatf("sweep%0d rv1", k), 32'(b_m1_rvalid), 32'(p1));
                check($sformatf("sweep%0d rd", k), p1 ? b_m1_rdata : b_m0_rdata, exp_rd);
            end else begin
                check($sformatf("sweep%0d no rv", k), 32'({b_m0_rvalid, b_m1_rvalid}), 32'd0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
